alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execution stage directly downstream of the reservation station. Accepts one issued ALU operation per cycle (`alu_ready`/`alu_oprand`/`a`/`b`/`alu_tag`), computes the 32-bit result through a one-register operand stage, and buffers results in a small FIFO. The FIFO presents results to the CDB arbiter as one 37-bit lane entry with a valid/grant handshake. Provides backpressure (`alu_free`) so the issuing stage never overruns the buffer, and discards all in-flight work on `flush`.

## Interface
- `FIFO_DEPTH`, 4: result buffer entries; power of two, ≥2.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rdy`  in  1  global enable; low freezes all state.
- `flush`  in  1  misprediction flush; discard all in-flight operations.
- `alu_ready`  in  1  issue valid.
- `alu_oprand`  in  5  opcode.
- `a`, `b`  in  32 each  operands.
- `alu_tag`  in  4  ROB tag of the operation.
- `alu_free`  out  1  issue may be accepted this cycle.
- `out_valid`  out  1  FIFO head holds a result.
- `out_tag`  out  4  head tag.
- `out_value`  out  32  head result.
- `cdb_grant`  in  1  arbiter takes head this cycle.

## Operation
- Opcodes (5-bit): ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, EQ 10, NE 11, LT 12, GE 13, LTU 14, GEU 15. Codes 16–31 produce result 0 but still retire their tag.
- Arithmetic wraps mod 2^32. Shift amount is `b[4:0]`. SLT/LT/GE are signed. SLTU/LTU/GEU are unsigned. Compare ops return 32'd0 or 32'd1.
- S1 register holds {valid, op, a, b, tag}. The result is computed combinationally from S1 and pushed into the FIFO on the next edge.
- `occupancy` = FIFO count + S1 valid. `alu_free` = (occupancy < FIFO_DEPTH), combinational from registers only.
- An issue is accepted when `alu_ready && alu_free && rdy && !flush`. `alu_ready` while `alu_free` is low is a protocol violation; the op is dropped. Flag it with an assertion.
- Pop occurs when `out_valid && cdb_grant && rdy`. Push and pop in the same cycle leave the count unchanged, including when the FIFO is full. Pointers wrap modulo FIFO_DEPTH.
- `flush` (with `rdy`): S1 valid, FIFO count and pointers clear on that edge. An issue or pop in the same cycle is ignored. `out_valid` = 0 the next cycle.
- `rdy` low: no issue, push, pop or flush takes effect. Outputs hold their values.
- Reset values: `out_valid` 0, `out_tag` 0, `out_value` 0, `alu_free` 1, S1 empty, FIFO empty. Reset asserted mid-operation clears everything immediately.

## Timing
- Issue in cycle t leads to S1 valid in t+1, which leads to FIFO entry with `out_valid` in t+2 if the FIFO was empty. Minimum latency is 2 cycles.
- Sustained throughput is one op per cycle when granted every cycle.
- Results leave in issue order.
- `out_*` come from the FIFO head register or array, with no combinational path from inputs.
- `alu_free` has no combinational path from `alu_ready` or `cdb_grant`.

## Structure
- Shared package `alu_pkg`: opcode localparams, `TAG_W`=4, `DATA_W`=32, lane width 37 ({valid, tag, value}, matching one CDB half).
- Sub-module `result_fifo` (parameterised width/depth, push/pop/flush, count output), reusable by the load/store unit.
- Result function `alu_compute(op, a, b)` lives in `alu_pkg`.

## Test plan
- Issue ADD a=5,b=7,tag=3 with grant held 1: `out_valid`=1, tag 3, value 12 exactly 2 cycles later; one cycle only.
- SRA a=0x80000000,b=0x21; SLTU a=1,b=0xFFFFFFFF; SUB a=0,b=1: values 0xC0000000, 1, 0xFFFFFFFF in issue order.
- Grant held 0, issue each cycle while `alu_free`: exactly 4 accepted, `alu_free` low after the 4th. Raise grant: tags drain in order, `alu_free` returns high the cycle after the first pop.
- FIFO full plus S1 push concurrent with pop: count stays constant, no entry lost or duplicated.
- `flush` with 2 FIFO entries, S1 valid and a new issue: next cycle `out_valid`=0, `alu_free`=1, no stale tag ever appears.
- `rdy`=0 for 3 cycles with grant=1 and a pending head: head unchanged and not popped. Async `rst_n` low mid-stream clears all outputs to 0 without a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU execution types, opcodes and result function.
// Used by the ALU execute stage and its result buffer.
package alu_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int OP_W   = 5;
  localparam int LANE_W = 1 + TAG_W + DATA_W;

  localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OP_W-1:0] OP_AND  = 5'd2;
  localparam logic [OP_W-1:0] OP_OR   = 5'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 5'd4;
  localparam logic [OP_W-1:0] OP_SLL  = 5'd5;
  localparam logic [OP_W-1:0] OP_SRL  = 5'd6;
  localparam logic [OP_W-1:0] OP_SRA  = 5'd7;
  localparam logic [OP_W-1:0] OP_SLT  = 5'd8;
  localparam logic [OP_W-1:0] OP_SLTU = 5'd9;
  localparam logic [OP_W-1:0] OP_EQ   = 5'd10;
  localparam logic [OP_W-1:0] OP_NE   = 5'd11;
  localparam logic [OP_W-1:0] OP_LT   = 5'd12;
  localparam logic [OP_W-1:0] OP_GE   = 5'd13;
  localparam logic [OP_W-1:0] OP_LTU  = 5'd14;
  localparam logic [OP_W-1:0] OP_GEU  = 5'd15;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } s1_t;

  function automatic logic [DATA_W-1:0] alu_compute(
    input logic [OP_W-1:0]   op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    logic [4:0]        sh;
    r  = '0;
    sh = b[4:0];
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $signed(a) >>> sh;
      OP_SLT,
      OP_LT:   r = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU,
      OP_LTU:  r = {31'd0, a < b};
      OP_EQ:   r = {31'd0, a == b};
      OP_NE:   r = {31'd0, a != b};
      OP_GE:   r = {31'd0, $signed(a) >= $signed(b)};
      OP_GEU:  r = {31'd0, a >= b};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_unit_result_fifo.sv
// Parameterised result buffer with push/pop/flush.
// Head entry is read straight from the storage array.
module result_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_dout  = r_mem[r_rd];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: operand register, result compute, result FIFO.
// Presents one CDB lane with valid/grant and issue backpressure.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        flush,
  input  logic        alu_ready,
  input  logic [4:0]  alu_oprand,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_tag,
  output logic        alu_free,
  output logic        out_valid,
  output logic [3:0]  out_tag,
  output logic [31:0] out_value,
  input  logic        cdb_grant
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = TAG_W + DATA_W;

  s1_t               r_s1;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic [DATA_W-1:0] w_result;
  logic [FW-1:0]     w_head;
  logic              w_fvalid;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_occ;
  logic [LANE_W-1:0] w_lane;

  assign w_occ    = w_count + {{(CW-1){1'b0}}, r_s1.valid};
  assign alu_free = (w_occ < CW'(FIFO_DEPTH));
  assign w_accept = alu_ready && alu_free && rdy && !flush;
  assign w_flush  = flush && rdy;
  assign w_push   = r_s1.valid && rdy && !flush;
  assign w_pop    = w_fvalid && cdb_grant && rdy && !flush;
  assign w_result = alu_compute(r_s1.op, r_s1.a, r_s1.b);

  assign w_lane    = {w_fvalid, w_head};
  assign out_valid = w_lane[LANE_W-1];
  assign out_tag   = w_lane[DATA_W +: TAG_W];
  assign out_value = w_lane[DATA_W-1:0];

  // Operand stage: capture accepted issue, drop on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_s1.valid <= 1'b0;
      end else begin
        r_s1.valid <= w_accept;
        if (w_accept) begin
          r_s1.op  <= alu_oprand;
          r_s1.a   <= a;
          r_s1.b   <= b;
          r_s1.tag <= alu_tag;
        end
      end
    end
  end

  result_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   ({r_s1.tag, w_result}),
    .o_dout  (w_head),
    .o_valid (w_fvalid),
    .o_count (w_count)
  );

  a_no_issue_when_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(alu_ready && !alu_free && rdy && !flush)
  );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit.
// Directed vectors, queue-based expected results.
module tb_alu_exec_unit;
  import alu_pkg::*;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] val;
  } exp_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        alu_ready = 1'b0;
  logic [4:0]  alu_oprand = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  alu_tag = '0;
  logic        cdb_grant = 1'b0;
  logic        alu_free;
  logic        out_valid;
  logic [3:0]  out_tag;
  logic [31:0] out_value;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  exp_t q[$];

  alu_exec_unit #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .flush      (flush),
    .alu_ready  (alu_ready),
    .alu_oprand (alu_oprand),
    .a          (a),
    .b          (b),
    .alu_tag    (alu_tag),
    .alu_free   (alu_free),
    .out_valid  (out_valid),
    .out_tag    (out_tag),
    .out_value  (out_value),
    .cdb_grant  (cdb_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare head against scoreboard, pop on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stale_out: got tag %0d value 0x%08h, expected none",
                 out_tag, out_value);
      end else begin
        check("head_tag", {28'd0, out_tag}, {28'd0, q[0].tag});
        check("head_value", out_value, q[0].val);
        if (cdb_grant && rdy && !flush) begin
          void'(q.pop_front());
          pops++;
        end
      end
    end
  end

  // Called at posedge+1; returns at the next posedge+1.
  task automatic issue(input logic [4:0] op, input logic [31:0] ia,
                       input logic [31:0] ib, input logic [3:0] t,
                       input logic [31:0] exp);
    int n;
    n = 0;
    while (!alu_free && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!alu_free) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: alu_free 0, expected 1");
    end else begin
      alu_ready  = 1'b1;
      alu_oprand = op;
      a          = ia;
      b          = ib;
      alu_tag    = t;
      if (rdy && !flush) q.push_back('{tag: t, val: exp});
      @(posedge clk); #1;
      alu_ready = 1'b0;
    end
  endtask

  task automatic wait_empty(input string name, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    check(name, q.size(), 0);
  endtask

  vec_t vecs[16] = '{
    '{OP_SRA,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000},
    '{OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001},
    '{OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
    '{OP_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000},
    '{OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0},
    '{OP_GE,   32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000},
    '{OP_GEU,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001},
    '{OP_LT,   32'h8000_0000, 32'h0000_0001, 32'h0000_0001},
    '{OP_EQ,   32'h0000_1234, 32'h0000_1234, 32'h0000_0001},
    '{OP_NE,   32'h0000_0005, 32'h0000_0005, 32'h0000_0000},
    '{OP_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00},
    '{OP_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000},
    '{5'd20,   32'h0000_0005, 32'h0000_0005, 32'h0000_0000},
    '{OP_SLT,  32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0000},
    '{OP_LTU,  32'h0000_0002, 32'h0000_0003, 32'h0000_0001},
    '{OP_OR,   32'h0000_0010, 32'h0000_0001, 32'h0000_0011}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int p0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_tag", {28'd0, out_tag}, 0);
    check("rst_out_value", out_value, 0);
    check("rst_alu_free", {31'd0, alu_free}, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: ADD 5+7 tag 3, grant held
    cdb_grant = 1'b1;
    issue(OP_ADD, 32'd5, 32'd7, 4'd3, 32'd12);
    check("lat_t1_valid", {31'd0, out_valid}, 0);
    @(posedge clk); #1;
    check("lat_t2_valid", {31'd0, out_valid}, 1);
    check("lat_t2_tag", {28'd0, out_tag}, 3);
    check("lat_t2_value", out_value, 12);
    @(posedge clk); #1;
    check("lat_t3_valid", {31'd0, out_valid}, 0);

    // Directed vectors back-to-back, in-order results
    for (int i = 0; i < 16; i++)
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), vecs[i].exp);
    wait_empty("vec_drain", 40);

    // Backpressure: grant low, fill to capacity
    cdb_grant = 1'b0;
    acc = 0;
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      if (alu_free) begin
        issue(OP_OR, 32'(i), 32'h100, 4'(i + 1), 32'(i) | 32'h100);
        acc++;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("bp_accepted", 32'(acc), 4);
    check("bp_free_low", {31'd0, alu_free}, 0);
    cdb_grant = 1'b1;
    check("bp_free_before_pop", {31'd0, alu_free}, 0);
    @(posedge clk); #1;
    check("bp_free_after_pop", {31'd0, alu_free}, 1);
    // Keep issuing while draining: push and pop together
    for (int i = 0; i < 4; i++)
      issue(OP_ADD, 32'(i), 32'd1000, 4'(9 + i), 32'(i) + 32'd1000);
    wait_empty("bp_drain", 40);
    check("bp_pop_count", 32'(pops - p0), 8);

    // Flush with 2 FIFO entries, S1 valid and a new issue
    cdb_grant = 1'b0;
    issue(OP_ADD, 32'd1, 32'd1, 4'd1, 32'd2);
    issue(OP_ADD, 32'd2, 32'd2, 4'd2, 32'd4);
    issue(OP_ADD, 32'd3, 32'd3, 4'd3, 32'd6);
    check("fl_pre_free", {31'd0, alu_free}, 1);
    flush      = 1'b1;
    alu_ready  = 1'b1;
    alu_oprand = OP_ADD;
    a          = 32'd4;
    b          = 32'd4;
    alu_tag    = 4'd4;
    @(posedge clk); #1;
    flush     = 1'b0;
    alu_ready = 1'b0;
    q.delete();
    check("fl_out_valid", {31'd0, out_valid}, 0);
    check("fl_alu_free", {31'd0, alu_free}, 1);
    cdb_grant = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("fl_quiet", {31'd0, out_valid}, 0);
    issue(OP_SUB, 32'd10, 32'd3, 4'd7, 32'd7);
    wait_empty("fl_after", 10);

    // rdy low freezes head
    cdb_grant = 1'b0;
    issue(OP_ADD, 32'd50, 32'd5, 4'd5, 32'd55);
    issue(OP_ADD, 32'd60, 32'd6, 4'd6, 32'd66);
    rdy = 1'b0;
    cdb_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rdy0_valid", {31'd0, out_valid}, 1);
      check("rdy0_tag", {28'd0, out_tag}, 5);
      check("rdy0_value", out_value, 55);
    end
    rdy = 1'b1;
    wait_empty("rdy_drain", 20);

    // Async reset mid-stream
    cdb_grant = 1'b0;
    issue(OP_XOR, 32'hA, 32'h5, 4'd9, 32'hF);
    issue(OP_AND, 32'hF, 32'h3, 4'd10, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 0);
    check("arst_out_tag", {28'd0, out_tag}, 0);
    check("arst_out_value", out_value, 0);
    check("arst_alu_free", {31'd0, alu_free}, 1);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_post_valid", {31'd0, out_valid}, 0);
    cdb_grant = 1'b1;
    issue(OP_ADD, 32'd1, 32'd2, 4'd11, 32'd3);
    wait_empty("final_drain", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
